// File: rtl/decode_stage_pipe_if.sv
// decode_stage_pipe_if: decode-stage bus (IF/ID inputs, hazard controls, writeback port, ID/EX outputs)
interface decode_stage_pipe_if #(parameter int DATA_W = 32, parameter int CTRL_W = 8);
   logic [31:0]       instr_D;
   logic [DATA_W-1:0] PCPlus4_D;
   logic [CTRL_W-1:0] ctrl_D;
   logic              branch_D;
   logic [1:0]        br_mode_D;
   logic              Jump_D;
   logic              forwardA_D;
   logic              forwardB_D;
   logic [DATA_W-1:0] ALU_out_M;
   logic              stall_D;
   logic              flush_E;
   logic              reg_write_W;
   logic [4:0]        A3_W;
   logic [DATA_W-1:0] WD3_W;
   logic [1:0]        PC_src_D;
   logic [DATA_W-1:0] PCbranch_D;
   logic [DATA_W-1:0] PCjump_D;
   logic [DATA_W-1:0] RD1_E;
   logic [DATA_W-1:0] RD2_E;
   logic [DATA_W-1:0] signImm_E;
   logic [4:0]        Rs_E;
   logic [4:0]        Rt_E;
   logic [4:0]        Rd_E;
   logic [CTRL_W-1:0] ctrl_E;
   logic              valid_E;
   modport master (
      output instr_D, PCPlus4_D, ctrl_D, branch_D, br_mode_D, Jump_D, forwardA_D, forwardB_D,
             ALU_out_M, stall_D, flush_E, reg_write_W, A3_W, WD3_W,
      input  PC_src_D, PCbranch_D, PCjump_D, RD1_E, RD2_E, signImm_E, Rs_E, Rt_E, Rd_E,
             ctrl_E, valid_E
   );
   modport slave (
      input  instr_D, PCPlus4_D, ctrl_D, branch_D, br_mode_D, Jump_D, forwardA_D, forwardB_D,
             ALU_out_M, stall_D, flush_E, reg_write_W, A3_W, WD3_W,
      output PC_src_D, PCbranch_D, PCjump_D, RD1_E, RD2_E, signImm_E, Rs_E, Rt_E, Rd_E,
             ctrl_E, valid_E
   );
endinterface

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: MIPS decode stage (regfile, branch resolve, targets, ID/EX); REGFILE_BYPASS_EN adds write-first reads
module decode_stage_pipe #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int CTRL_W   = 8
) (
   input logic clk,
   input logic reset,
   decode_stage_pipe_if.slave bus
);
   typedef struct packed {
      logic              valid;
      logic [CTRL_W-1:0] ctrl;
      logic [4:0]        rs;
      logic [4:0]        rt;
      logic [4:0]        rd;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
   } ide_t;
   logic [DATA_W-1:0] regs_q [32];
   logic [DATA_W-1:0] regs_d [32];
   logic [4:0]        rs, rt, rd;
   logic [DATA_W-1:0] sign_imm, rd1, rd2, op_a, op_b;
   logic              we, eq, lez, cond;
   ide_t              ide_d, ide_q;
   assign rs       = bus.instr_D[25:21];
   assign rt       = bus.instr_D[20:16];
   assign rd       = bus.instr_D[15:11];
   assign sign_imm = {{(DATA_W-16){bus.instr_D[15]}}, bus.instr_D[15:0]};
   assign we       = bus.reg_write_W && bus.A3_W != 5'd0 && int'(bus.A3_W) < NUM_REGS;
   always_comb begin
      for (int i = 0; i < 32; i++) regs_d[i] = (we && bus.A3_W == 5'(i)) ? bus.WD3_W : regs_q[i];
   end
`ifdef REGFILE_BYPASS_EN
   logic byp;
   assign byp = bus.reg_write_W && bus.A3_W != 5'd0;
`endif
   always_comb begin
      rd1 = (rs == 5'd0 || int'(rs) >= NUM_REGS) ? '0 : regs_q[rs];
      rd2 = (rt == 5'd0 || int'(rt) >= NUM_REGS) ? '0 : regs_q[rt];
`ifdef REGFILE_BYPASS_EN
      rd1 = (byp && bus.A3_W == rs) ? bus.WD3_W : rd1;
      rd2 = (byp && bus.A3_W == rt) ? bus.WD3_W : rd2;
`endif
   end
   assign op_a = bus.forwardA_D ? bus.ALU_out_M : rd1;
   assign op_b = bus.forwardB_D ? bus.ALU_out_M : rd2;
   assign eq   = op_a == op_b;
   assign lez  = op_a[DATA_W-1] | ~|op_a;
   assign cond = bus.br_mode_D[1] ? (bus.br_mode_D[0] ? ~lez : lez) : (bus.br_mode_D[0] ? ~eq : eq);
   assign bus.PC_src_D   = {bus.Jump_D & ~bus.stall_D, bus.branch_D & cond & ~bus.Jump_D & ~bus.stall_D};
   assign bus.PCbranch_D = bus.PCPlus4_D + (sign_imm << 2);
   assign bus.PCjump_D   = {bus.PCPlus4_D[DATA_W-1:28], bus.instr_D[25:0], 2'b00};
   // ID/EX captures raw regfile reads; D-stage forwarding only feeds the comparator
   always_comb begin
      ide_d = (bus.flush_E | bus.stall_D) ? '0 : ide_t'{1'b1, bus.ctrl_D, rs, rt, rd, sign_imm, rd1, rd2};
   end
   always_ff @(posedge clk) begin
      ide_q <= reset ? '0 : ide_d;
      for (int i = 0; i < 32; i++) regs_q[i] <= reset ? '0 : regs_d[i];
   end
   assign bus.valid_E   = ide_q.valid;
   assign bus.ctrl_E    = ide_q.ctrl;
   assign bus.Rs_E      = ide_q.rs;
   assign bus.Rt_E      = ide_q.rt;
   assign bus.Rd_E      = ide_q.rd;
   assign bus.signImm_E = ide_q.imm;
   assign bus.RD1_E     = ide_q.rd1;
   assign bus.RD2_E     = ide_q.rd2;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed scoreboard bench for decode_stage_pipe
module tb_decode_stage_pipe;
   logic clk = 1'b0;
   logic reset;
   decode_stage_pipe_if #(.DATA_W(32), .CTRL_W(8)) bus();
   decode_stage_pipe dut (.clk(clk), .reset(reset), .bus(bus.slave));
   always #5 clk = ~clk;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic [31:0]  regs [32];
   logic [119:0] exp_q [$];
   int total = 0;
   int passed = 0;
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask
   function automatic logic [31:0] mread(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (BYP && bus.reg_write_W && bus.A3_W == a) return bus.WD3_W;
      return regs[a];
   endfunction
   task automatic cyc(input string tag);
      logic [4:0]   rs, rt, rd;
      logic [15:0]  imm;
      logic [119:0] e, o;
      rs  = bus.instr_D[25:21];
      rt  = bus.instr_D[20:16];
      rd  = bus.instr_D[15:11];
      imm = bus.instr_D[15:0];
      e = (reset | bus.flush_E | bus.stall_D) ? '0 :
          {1'b1, bus.ctrl_D, rs, rt, rd, {{16{imm[15]}}, imm}, mread(rs), mread(rt)};
      exp_q.push_back(e);
      @(posedge clk);
      if (reset) foreach (regs[i]) regs[i] = 32'h0;
      else if (bus.reg_write_W && bus.A3_W != 5'd0) regs[bus.A3_W] = bus.WD3_W;
      #1;
      o = {bus.valid_E, bus.ctrl_E, bus.Rs_E, bus.Rt_E, bus.Rd_E, bus.signImm_E, bus.RD1_E, bus.RD2_E};
      chk(tag, o, exp_q.pop_front());
   endtask
   task automatic br(input logic [1:0] mode, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
      bus.branch_D  = 1'b1;
      bus.br_mode_D = mode;
      bus.instr_D   = {6'h04, rs, rt, imm};
      #1;
   endtask
   task automatic wr(input logic [4:0] a, input logic [31:0] d, input string tag);
      bus.reg_write_W = 1'b1;
      bus.A3_W        = a;
      bus.WD3_W       = d;
      cyc(tag);
      bus.reg_write_W = 1'b0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      reset = 1'b1;
      bus.instr_D = '0; bus.PCPlus4_D = '0; bus.ctrl_D = '0; bus.branch_D = 1'b0;
      bus.br_mode_D = 2'b00; bus.Jump_D = 1'b0; bus.forwardA_D = 1'b0; bus.forwardB_D = 1'b0;
      bus.ALU_out_M = '0; bus.stall_D = 1'b0; bus.flush_E = 1'b0; bus.reg_write_W = 1'b0;
      bus.A3_W = '0; bus.WD3_W = '0;
      cyc("reset_bubble0");
      cyc("reset_bubble1");
      chk("reset_pcsrc", bus.PC_src_D, 2'b00);
      reset = 1'b0;
      bus.ctrl_D = 8'hA5;
      wr(5'd5, 32'h0000_1234, "wr_r5");
      wr(5'd6, 32'h0000_1234, "wr_r6");
      wr(5'd7, 32'hFFFF_FFFF, "wr_r7");
      wr(5'd9, 32'h0000_0055, "wr_r9");
      wr(5'd3, 32'h0000_0011, "wr_r3");
      bus.PCPlus4_D = 32'h100;
      br(2'b00, 5'd5, 5'd6, 16'h0004);
      chk("beq_src", bus.PC_src_D, 2'b01);
      chk("beq_target", bus.PCbranch_D, 32'h110);
      bus.br_mode_D = 2'b01; #1;
      chk("bne_src", bus.PC_src_D, 2'b00);
      bus.ctrl_D = 8'h3C;
      cyc("beq_capture");
      br(2'b10, 5'd7, 5'd0, 16'hFFFF);
      chk("blez_neg", bus.PC_src_D, 2'b01);
      chk("neg_imm_target", bus.PCbranch_D, 32'h0FC);
      br(2'b11, 5'd8, 5'd0, 16'h0);
      chk("bgtz_zero", bus.PC_src_D, 2'b00);
      br(2'b10, 5'd8, 5'd0, 16'h0);
      chk("blez_zero", bus.PC_src_D, 2'b01);
      br(2'b11, 5'd5, 5'd0, 16'h0);
      chk("bgtz_pos", bus.PC_src_D, 2'b01);
      br(2'b11, 5'd7, 5'd0, 16'h0);
      chk("bgtz_neg", bus.PC_src_D, 2'b00);
      bus.PCPlus4_D = 32'hFFFF_FFFC;
      br(2'b00, 5'd5, 5'd6, 16'h0001);
      chk("wrap_target", bus.PCbranch_D, 32'h0);
      cyc("wrap_capture");
      bus.PCPlus4_D = 32'h100;
      bus.ALU_out_M = 32'h55;
      bus.forwardA_D = 1'b1;
      br(2'b00, 5'd8, 5'd9, 16'h0);
      chk("fwdA_src", bus.PC_src_D, 2'b01);
      bus.forwardA_D = 1'b0; #1;
      chk("nofwd_src", bus.PC_src_D, 2'b00);
      bus.forwardB_D = 1'b1;
      br(2'b00, 5'd9, 5'd8, 16'h0);
      chk("fwdB_src", bus.PC_src_D, 2'b01);
      bus.forwardB_D = 1'b0;
      bus.forwardA_D = 1'b1;
      br(2'b00, 5'd8, 5'd9, 16'h0);
      cyc("fwd_raw_capture");
      bus.forwardA_D = 1'b0;
      bus.Jump_D = 1'b1;
      bus.branch_D = 1'b1;
      bus.br_mode_D = 2'b00;
      bus.PCPlus4_D = 32'h4000_0008;
      bus.instr_D = {6'h02, 26'h000_0010};
      #1;
      chk("jump_src", bus.PC_src_D, 2'b10);
      chk("jump_target", bus.PCjump_D, 32'h4000_0040);
      bus.stall_D = 1'b1; #1;
      chk("stall_src", bus.PC_src_D, 2'b00);
      cyc("stall_bubble");
      bus.stall_D = 1'b0;
      bus.flush_E = 1'b1; #1;
      chk("flush_src", bus.PC_src_D, 2'b10);
      cyc("flush_bubble");
      bus.stall_D = 1'b1;
      cyc("stall_flush_bubble");
      bus.stall_D = 1'b0;
      bus.flush_E = 1'b0;
      bus.Jump_D = 1'b0;
      bus.branch_D = 1'b0;
      cyc("resume_capture");
      wr(5'd0, 32'h0000_DEAD, "wr_r0");
      br(2'b11, 5'd0, 5'd0, 16'h0);
      chk("r0_bgtz", bus.PC_src_D, 2'b00);
      cyc("r0_read");
      bus.reg_write_W = 1'b1;
      bus.A3_W = 5'd3;
      bus.WD3_W = 32'h77;
      bus.ALU_out_M = 32'h77;
      bus.forwardB_D = 1'b1;
      br(2'b00, 5'd3, 5'd3, 16'h0);
      chk("bypass_cmp", bus.PC_src_D, BYP ? 2'b01 : 2'b00);
      bus.forwardB_D = 1'b0;
      cyc("bypass_capture");
      bus.reg_write_W = 1'b0;
      bus.forwardB_D = 1'b1; #1;
      chk("r3_written", bus.PC_src_D, 2'b01);
      bus.forwardB_D = 1'b0;
      reset = 1'b1;
      bus.reg_write_W = 1'b1;
      bus.WD3_W = 32'h99;
      cyc("reset_write");
      reset = 1'b0;
      bus.reg_write_W = 1'b0;
      br(2'b10, 5'd3, 5'd5, 16'h0);
      chk("r3_zero_blez", bus.PC_src_D, 2'b01);
      cyc("r3_cleared");
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
